// File: rtl/burst_addr_collector.sv
// burst_addr_collector
// Collapses a per-beat address stream back into burst descriptors
// (start address + offset of last beat). Runs of consecutive addresses form
// one burst. A burst closes when it reaches its maximum length, when a
// non-consecutive beat arrives, or when flush is held high.
// Optional feature macro: BURST_COLLECT_STATS_EN adds stat_bursts, a
// saturating count of emitted descriptors.
module burst_addr_collector #(
    parameter int ADDR_WIDTH    = 20,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_WIDTH-1:0]    in_addr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_WIDTH-1:0]    out_start_addr,
    output logic [COUNTER_WIDTH-1:0] out_count,
`ifdef BURST_COLLECT_STATS_EN
    output logic [15:0]              stat_bursts,
`endif
    output logic                     busy
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = CNT_MAX - COUNTER_WIDTH'(1);

    logic [0:0]               state_q, state_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]    out_start_addr_q, out_start_addr_d;
    logic [COUNTER_WIDTH-1:0] out_count_q, out_count_d;

    logic                     out_free;
    logic                     accept;
    logic                     contig;
    logic [ADDR_WIDTH:0]      next_addr;
    logic                     emit;
    logic [ADDR_WIDTH-1:0]    emit_base;
    logic [COUNTER_WIDTH-1:0] emit_cnt;

    // Handshake and contiguity; the extra top bit makes an address wrap a burst break.
    always_comb begin
        out_free  = ~out_valid_q | out_ready;
        in_ready  = out_free & ~flush;
        accept    = in_valid & in_ready;
        next_addr = {1'b0, base_q}
                  + {{(ADDR_WIDTH + 1 - COUNTER_WIDTH){1'b0}}, cnt_q}
                  + (ADDR_WIDTH + 1)'(1);
        contig    = ({1'b0, in_addr} == next_addr);
    end

    // Burst tracking FSM and output register loading.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        cnt_d            = cnt_q;
        out_valid_d      = out_valid_q & ~out_ready;
        out_start_addr_d = out_start_addr_q;
        out_count_d      = out_count_q;
        emit             = 1'b0;
        emit_base        = base_q;
        emit_cnt         = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    base_d  = in_addr;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                if (accept) begin
                    if (contig) begin
                        if (cnt_q == CNT_LAST) begin
                            emit     = 1'b1;
                            emit_cnt = CNT_MAX;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt_q + COUNTER_WIDTH'(1);
                        end
                    end else begin
                        emit   = 1'b1;
                        base_d = in_addr;
                        cnt_d  = '0;
                    end
                end else if (flush && out_free) begin
                    emit    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        if (emit) begin
            out_valid_d      = 1'b1;
            out_start_addr_d = emit_base;
            out_count_d      = emit_cnt;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            base_q           <= '0;
            cnt_q            <= '0;
            out_valid_q      <= 1'b0;
            out_start_addr_q <= '0;
            out_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            cnt_q            <= cnt_d;
            out_valid_q      <= out_valid_d;
            out_start_addr_q <= out_start_addr_d;
            out_count_q      <= out_count_d;
        end
    end

`ifdef BURST_COLLECT_STATS_EN
    logic [15:0] stat_q, stat_d;

    // Saturating count of emitted descriptors.
    always_comb begin
        stat_d = stat_q;
        if (emit && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    // Statistics register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_bursts = stat_q;
`endif

    assign out_valid      = out_valid_q;
    assign out_start_addr = out_start_addr_q;
    assign out_count      = out_count_q;
    assign busy           = (state_q == COLLECT);

endmodule
